// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard
//   over the shared open-drain clock/data lines. It requests to send by
//   inhibiting the clock, then presenting the start bit. After that it shifts
//   out d0..d7, odd parity and stop on the device's falling clock edges, and
//   finally checks the device's ack bit.
//
// Ports
//   clk_i         in   system clock (the only clock domain)
//   rst_n_i       in   asynchronous active-low reset
//   req_i         in   start a transfer of data_i (accepted only while busy_o=0)
//   data_i        in   [7:0] byte to send, captured on acceptance
//   busy_o        out  transfer in progress
//   done_o        out  1-cycle pulse: byte sent and acked by the device
//   error_o       out  1-cycle pulse: NACK or timeout
//   ps2_clk_i     in   PS/2 clock line level (asynchronous)
//   ps2_dat_i     in   PS/2 data line level (asynchronous)
//   ps2_clk_oe_o  out  1 = pull PS/2 clock low, 0 = release
//   ps2_dat_oe_o  out  1 = pull PS/2 data low, 0 = release

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t state, state_nxt;

  logic          clk_meta, sync_clk, sync_clk_d;
  logic          dat_meta, sync_dat;
  logic          fall;

  logic [9:0]    frame, frame_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [IW-1:0] inh_cnt, inh_cnt_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          tmo_hit;

  logic          busy_nxt, done_nxt, error_nxt, clk_oe_nxt, dat_oe_nxt;

  // Synchronisers reset to 1 (the idle line level) so that coming out of
  // reset never looks like a falling clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_meta   <= 1'b1;
      sync_clk   <= 1'b1;
      sync_clk_d <= 1'b1;
      dat_meta   <= 1'b1;
      sync_dat   <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk_i;
      sync_clk   <= clk_meta;
      sync_clk_d <= sync_clk;
      dat_meta   <= ps2_dat_i;
      sync_dat   <= dat_meta;
    end
  end

  assign fall    = sync_clk_d & ~sync_clk;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // State register together with every registered output and counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      frame        <= '0;
      bit_cnt      <= '0;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      ps2_clk_oe_o <= 1'b0;
      ps2_dat_oe_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame        <= frame_nxt;
      bit_cnt      <= bit_cnt_nxt;
      inh_cnt      <= inh_cnt_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      busy_o       <= busy_nxt;
      done_o       <= done_nxt;
      error_o      <= error_nxt;
      ps2_clk_oe_o <= clk_oe_nxt;
      ps2_dat_oe_o <= dat_oe_nxt;
    end
  end

  // Next-state and next-output logic. Falls seen in INHIBIT/REQ are ignored
  // because those states never look at 'fall'.
  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame;
    bit_cnt_nxt = bit_cnt;
    inh_cnt_nxt = inh_cnt;
    tmo_cnt_nxt = tmo_cnt;
    busy_nxt    = busy_o;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;
    clk_oe_nxt  = ps2_clk_oe_o;
    dat_oe_nxt  = ps2_dat_oe_o;

    case (state)
      IDLE: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        busy_nxt   = 1'b0;
        if (req_i && !busy_o) begin
          // Frame is shifted out LSB first: d0..d7, odd parity, stop.
          frame_nxt   = {1'b1, ~^data_i, data_i};
          inh_cnt_nxt = '0;
          busy_nxt    = 1'b1;
          clk_oe_nxt  = 1'b1;
          state_nxt   = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_oe_nxt = 1'b1;
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          dat_oe_nxt = 1'b1;
          state_nxt  = REQ;
        end else begin
          inh_cnt_nxt = inh_cnt + IW'(1);
        end
      end

      REQ: begin
        // Release the clock with data held low: this is the start bit.
        clk_oe_nxt  = 1'b0;
        dat_oe_nxt  = 1'b1;
        bit_cnt_nxt = '0;
        tmo_cnt_nxt = '0;
        state_nxt   = SEND;
      end

      SEND: begin
        if (fall) begin
          dat_oe_nxt  = ~frame[bit_cnt];
          tmo_cnt_nxt = '0;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            state_nxt = ACK;
          end
        end else if (tmo_hit) begin
          clk_oe_nxt = 1'b0;
          dat_oe_nxt = 1'b0;
          error_nxt  = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end

      ACK: begin
        if (fall) begin
          tmo_cnt_nxt = '0;
          if (!sync_dat) begin
            state_nxt = WAIT_IDLE;
          end else begin
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else if (tmo_hit) begin
          clk_oe_nxt = 1'b0;
          dat_oe_nxt = 1'b0;
          error_nxt  = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end

      WAIT_IDLE: begin
        // The device must let both lines float high before we call it done.
        if (sync_clk && sync_dat) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          clk_oe_nxt = 1'b0;
          dat_oe_nxt = 1'b0;
          error_nxt  = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end

      default: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Bench for ps2_host_tx with a simple PS/2 device model on the open-drain
//   lines. Expected outcomes go into a queue when a transfer is started, and
//   a monitor pops them whenever done_o or error_o pulses.

module tb_ps2_host_tx;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       req_i;
  logic [7:0] data_i;
  logic       busy_o, done_o, error_o;
  logic       ps2_clk_i, ps2_dat_i;
  logic       ps2_clk_oe_o, ps2_dat_oe_o;

  // Device side of the open-drain lines.
  logic       dev_clk;
  logic       dev_dat_pull;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe_o;
  assign ps2_dat_i = ~dev_dat_pull & ~ps2_dat_oe_o;

  ps2_host_tx #(
    .INHIBIT_CYCLES(8),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_i        (req_i),
    .data_i       (data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .ps2_clk_oe_o (ps2_clk_oe_o),
    .ps2_dat_oe_o (ps2_dat_oe_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    bit         chk_frame;
    logic [9:0] frame;
    int         exp_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         n_error = 0;
  logic [9:0] bfm_frame = '0;
  int         last_fall_cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_exp(input bit is_done, input bit chk_frame, input logic [9:0] frame, input int exp_cyc);
    exp_t e;
    e.is_done   = is_done;
    e.chk_frame = chk_frame;
    e.frame     = frame;
    e.exp_cyc   = exp_cyc;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    data_i = data;
    req_i  = 1'b1;
    tick(1);
    req_i  = 1'b0;
  endtask

  // Device waits for request-to-send: clock released, data held low.
  task automatic bfm_wait_rts();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (!ps2_clk_oe_o && ps2_dat_oe_o) ok = 1'b1;
      else tick(1);
    end
    checkOutput("rts_seen", {31'd0, ok}, 32'd1);
  endtask

  // Device clocks n bits, latching the data line on each rising edge.
  task automatic bfm_clock_bits(input int n);
    for (int i = 0; i < n; i++) begin
      tick(20);
      dev_clk       = 1'b0;
      last_fall_cyc = cyc;
      tick(20);
      dev_clk       = 1'b1;
      bfm_frame[i]  = ps2_dat_i;
    end
  endtask

  task automatic bfm_ack(input bit do_ack);
    tick(10);
    if (do_ack) dev_dat_pull = 1'b1;
    tick(10);
    dev_clk = 1'b0;
    tick(20);
    dev_clk = 1'b1;
    tick(5);
    dev_dat_pull = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy_o; i++) tick(1);
    checkOutput("idle_reached", {31'd0, busy_o}, 32'd0);
  endtask

  // Monitor: pops one expectation per done_o/error_o pulse.
  initial begin
    exp_t e;
    bit   pulse_prev = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (pulse_prev) begin
        checkOutput("pulse_width", {30'd0, done_o, error_o}, 32'd0);
        pulse_prev = 1'b0;
      end
      if (done_o || error_o) begin
        pulse_prev = 1'b1;
        if (done_o) n_done++;
        if (error_o) n_error++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL spurious_pulse: got done=%0b error=%0b, expected no pulse", done_o, error_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_kind", {31'd0, done_o}, {31'd0, e.is_done});
          checkOutput("error_kind", {31'd0, error_o}, {31'd0, !e.is_done});
          checkOutput("busy_drop", {31'd0, busy_o}, 32'd0);
          checkOutput("clk_released", {31'd0, ps2_clk_oe_o}, 32'd0);
          checkOutput("dat_released", {31'd0, ps2_dat_oe_o}, 32'd0);
          if (e.chk_frame) checkOutput("frame_bits", {22'd0, bfm_frame}, {22'd0, e.frame});
          if (e.exp_cyc != 0) checkOutput("timeout_cycle", cyc, e.exp_cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected end of run");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n_i      = 1'b0;
    req_i        = 1'b0;
    data_i       = 8'h00;
    dev_clk      = 1'b1;
    dev_dat_pull = 1'b0;
    tick(3);
    checkOutput("rst_busy",   {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done",   {31'd0, done_o}, 32'd0);
    checkOutput("rst_error",  {31'd0, error_o}, 32'd0);
    checkOutput("rst_clk_oe", {31'd0, ps2_clk_oe_o}, 32'd0);
    checkOutput("rst_dat_oe", {31'd0, ps2_dat_oe_o}, 32'd0);
    rst_n_i = 1'b1;
    tick(2);

    // 0xED: six ones, parity 1, stop 1.
    push_exp(1'b1, 1'b1, 10'h3ED, 0);
    applyStimulus(8'hED);
    checkOutput("busy_after_req", {31'd0, busy_o}, 32'd1);
    bfm_wait_rts();
    bfm_clock_bits(10);
    bfm_ack(1'b1);
    wait_idle(100);
    tick(2);

    // 0x01 then 0x00, second request accepted in the done cycle.
    push_exp(1'b1, 1'b1, 10'h201, 0);
    applyStimulus(8'h01);
    bfm_wait_rts();
    bfm_clock_bits(10);
    bfm_ack(1'b1);
    data_i = 8'h00;
    req_i  = 1'b1;
    push_exp(1'b1, 1'b1, 10'h300, 0);
    for (int i = 0; i < 100 && !done_o; i++) tick(1);
    checkOutput("b2b_done_seen", {31'd0, done_o}, 32'd1);
    tick(1);
    checkOutput("b2b_busy_again", {31'd0, busy_o}, 32'd1);
    req_i = 1'b0;
    bfm_wait_rts();
    bfm_clock_bits(10);
    bfm_ack(1'b1);
    wait_idle(100);
    tick(2);

    // NACK: device leaves data high on the ack clock.
    push_exp(1'b0, 1'b1, 10'h30F, 0);
    applyStimulus(8'h0F);
    bfm_wait_rts();
    bfm_clock_bits(10);
    bfm_ack(1'b0);
    wait_idle(100);
    tick(2);

    // Timeout: device stops after 4 bits; d3=0 keeps data pulled low.
    // Error lands 3 sync cycles + 200 timeout cycles after the pad fall.
    applyStimulus(8'h30);
    bfm_wait_rts();
    bfm_clock_bits(4);
    checkOutput("dat_held_d3", {31'd0, ps2_dat_oe_o}, 32'd1);
    push_exp(1'b0, 1'b0, 10'h000, last_fall_cyc + 203);
    wait_idle(300);
    tick(2);

    // Reset in the middle of SEND (bit 3).
    applyStimulus(8'h77);
    bfm_wait_rts();
    bfm_clock_bits(3);
    tick(20);
    dev_clk = 1'b0;
    tick(10);
    #3;
    rst_n_i = 1'b0;
    #1;
    checkOutput("mid_rst_busy",   {31'd0, busy_o}, 32'd0);
    checkOutput("mid_rst_done",   {31'd0, done_o}, 32'd0);
    checkOutput("mid_rst_error",  {31'd0, error_o}, 32'd0);
    checkOutput("mid_rst_clk_oe", {31'd0, ps2_clk_oe_o}, 32'd0);
    checkOutput("mid_rst_dat_oe", {31'd0, ps2_dat_oe_o}, 32'd0);
    dev_clk = 1'b1;
    tick(2);
    rst_n_i = 1'b1;
    tick(2);

    // Clean transfer after reset: 8 inhibit cycles, then one REQ cycle.
    push_exp(1'b1, 1'b1, 10'h280, 0);
    applyStimulus(8'h80);
    n = 0;
    while (ps2_clk_oe_o && !ps2_dat_oe_o && n < 50) begin
      n++;
      tick(1);
    end
    checkOutput("inhibit_len", n, 32'd8);
    checkOutput("req_clk_oe", {31'd0, ps2_clk_oe_o}, 32'd1);
    checkOutput("req_dat_oe", {31'd0, ps2_dat_oe_o}, 32'd1);
    bfm_wait_rts();
    bfm_clock_bits(10);
    bfm_ack(1'b1);
    wait_idle(100);
    tick(2);

    // A request while busy must be ignored.
    push_exp(1'b1, 1'b1, 10'h35A, 0);
    applyStimulus(8'h5A);
    tick(3);
    data_i = 8'hAA;
    req_i  = 1'b1;
    tick(1);
    req_i  = 1'b0;
    bfm_wait_rts();
    bfm_clock_bits(10);
    bfm_ack(1'b1);
    wait_idle(100);
    tick(20);

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    checkOutput("done_count", n_done, 32'd5);
    checkOutput("error_count", n_error, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
